blink_monitor: RTL and testbench
================================

Name: blink_monitor

Overview:
- Checker stage directly downstream of the blinker; consumes its `led` and `flg` outputs.
- Verifies that wrap pulses arrive at exactly the blinker period and that the LED toggles after every pulse.
- Reports lock status, a sticky first-fault code, and a saturating count of good periods.
- Feeds status logic and formal harnesses that check the blinker in-system.

Parameters:
- PERIOD, 16384, expected clocks between consecutive flg pulses (2^CBITS of the blinker).
- GBITS, 14, gap counter width; must satisfy 2^GBITS >= PERIOD.
- LOCK_N, 2, consecutive good periods required to assert locked (1..15).
- CNT_W, 8, width of the good-period counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high; forces every register to its reset value immediately.
- led_in  in  1  blinker led output.
- flg_in  in  1  blinker flg output; one-cycle pulse per wrap.
- clr  in  1  synchronous clear of fault/status; returns FSM to IDLE.
- locked  out  1  high while in LOCKED.
- err  out  1  sticky fault flag.
- err_code  out  2  first fault: 0 none, 1 early pulse, 2 missing pulse, 3 led not toggled.
- good_cnt  out  CNT_W  count of good periods; saturates at all-ones.

Behaviour:
- Reset values: locked=0, err=0, err_code=0, good_cnt=0, state=IDLE, gap=0, last_led=0, chk_pend=0, run=0.
- All outputs are registered. Any event detected in cycle N is visible on outputs in cycle N+1.
- Gap counter:
  - Cleared to 0 on any cycle with flg_in=1; otherwise increments.
  - In TRACK/LOCKED it never exceeds PERIOD-1.
  - In IDLE/FAULT it holds at 0.
- LED sample point: the cycle immediately after a flg_in=1 cycle. The blinker updates led one cycle after flg.
  - chk_pend is set on every flg_in=1 cycle in IDLE/TRACK/LOCKED and cleared the next cycle.
- States:
  - IDLE:
    - flg_in=1 -> TRACK, with gap=0 and run=0.
    - The first sample point after entry stores led_in into last_led and performs no compare.
  - TRACK/LOCKED, evaluated each cycle:
    - flg_in=1 with gap != PERIOD-1 -> FAULT, code 1 (early). This includes flg high on two consecutive cycles.
    - flg_in=0 with gap == PERIOD-1 -> FAULT, code 2 (missing).
    - At a sample point, led_in == last_led -> FAULT, code 3 (no toggle). Otherwise last_led <= led_in and the period is good.
    - A good period increments run (saturating at LOCK_N) and good_cnt (saturating).
  - TRACK -> LOCKED when run reaches LOCK_N.
  - LOCKED stays until a fault occurs.
  - FAULT:
    - err=1, err_code holds the first code; subsequent faults are ignored.
    - locked=0; good_cnt frozen.
    - Exits only via clr or rst.
- Simultaneous events:
  - Sample point and early flg in the same cycle: code 1 wins.
  - clr in the same cycle as any detection: clr wins. Next state is IDLE; err, err_code, good_cnt and run all go to 0.
- clr in any state -> IDLE with all status cleared, the same as reset except synchronous.
- rst asserted mid-period or mid-check drops all state immediately. Pending checks are discarded.

Test Plan:
- PERIOD=8, LOCK_N=2; ideal stream (flg every 8 cycles, led toggling the cycle after each flg) -> good_cnt=1 after the 2nd pulse's check, locked=1 the cycle after the 3rd pulse's sample point; err=0 throughout.
- PERIOD=8; after lock, inject flg with gap=5 -> cycle after: err=1, err_code=1, locked=0; a later missing pulse leaves err_code=1.
- PERIOD=8; after lock, suppress one flg -> err=1, err_code=2 the cycle after the gap reaches 7 with flg_in=0.
- PERIOD=8; correct pulse timing but led held constant across a pulse -> err_code=3 one cycle after that sample point; good_cnt frozen at its prior value.
- In FAULT, assert clr while an early flg occurs -> next cycle: state IDLE, err=0, err_code=0, good_cnt=0; a fresh ideal stream relocks.
- CNT_W=2, long ideal stream -> good_cnt stops at 3. Assert rst asynchronously mid-gap -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/blink_monitor.sv
// blink_monitor: checks blinker wrap-pulse period and led toggling; reports lock, first fault and good-period count
module blink_monitor #(
  parameter int PERIOD = 16384,
  parameter int GBITS  = 14,
  parameter int LOCK_N = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             led_in,
  input  logic             flg_in,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] good_cnt
);
  typedef enum logic [1:0] {IDLE, TRACK, LOCKED, FAULT} state_t;
  localparam logic [GBITS-1:0] LAST = GBITS'(PERIOD - 1);
  localparam logic [3:0] LOCK_V = 4'(LOCK_N);
  state_t state;
  logic [GBITS-1:0] gap;
  logic [3:0] run, run_nx;
  logic last_led, chk_pend, prime;
  logic [1:0] code;
  always_comb begin
    code = (flg_in && gap != LAST) ? 2'd1 :
           (!flg_in && gap == LAST) ? 2'd2 :
           (chk_pend && !prime && led_in == last_led) ? 2'd3 : 2'd0;
    run_nx = (run == LOCK_V) ? run : run + 1'b1;
  end
  // prime marks the first sample point after leaving IDLE: it seeds last_led without comparing
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      state    <= IDLE;
      gap      <= '0;
      run      <= '0;
      last_led <= 1'b0;
      chk_pend <= 1'b0;
      prime    <= 1'b0;
      locked   <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
      good_cnt <= '0;
    end else begin
      chk_pend <= flg_in && state != FAULT;
      case (state)
        IDLE: if (flg_in) begin
          state <= TRACK;
          gap   <= '0;
          run   <= '0;
          prime <= 1'b1;
        end
        TRACK, LOCKED: if (code != 2'd0) begin
          state    <= FAULT;
          gap      <= '0;
          locked   <= 1'b0;
          err      <= 1'b1;
          err_code <= code;
        end else begin
          gap <= flg_in ? '0 : gap + 1'b1;
          if (chk_pend) begin
            last_led <= led_in;
            prime    <= 1'b0;
            if (!prime) begin
              run      <= run_nx;
              good_cnt <= &good_cnt ? good_cnt : good_cnt + 1'b1;
              if (run_nx == LOCK_V) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end
        end
        default: gap <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_blink_monitor.sv
// tb_blink_monitor: directed checks of blink_monitor with PERIOD=8, LOCK_N=2
module tb_blink_monitor;
  logic clk = 1'b0, rst = 1'b1, led_in = 1'b0, flg_in = 1'b0, clr = 1'b0;
  logic locked, err, s_locked, s_err;
  logic [1:0] err_code, s_code, s_cnt;
  logic [7:0] good_cnt;
  logic led = 1'b0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  blink_monitor #(.PERIOD(8), .GBITS(3), .LOCK_N(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .led_in(led_in), .flg_in(flg_in), .clr(clr),
    .locked(locked), .err(err), .err_code(err_code), .good_cnt(good_cnt));

  blink_monitor #(.PERIOD(8), .GBITS(3), .LOCK_N(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .led_in(led_in), .flg_in(flg_in), .clr(clr),
    .locked(s_locked), .err(s_err), .err_code(s_code), .good_cnt(s_cnt));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // drive one cycle from 1ns after an edge; returns 1ns after the next edge
  task automatic cyc(input logic f, input logic l);
    flg_in = f;
    led_in = l;
    @(posedge clk);
    #1;
  endtask

  // flg pulse then the sample-point cycle; the blinker's led changes one cycle after flg
  task automatic pulse(input bit tog);
    cyc(1'b1, led);
    if (tog) led = ~led;
    cyc(1'b0, led);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, led);
  endtask

  task automatic status(input string tag, input int lk, input int e, input int c, input int g);
    check({tag, ".locked"}, 32'(locked), lk);
    check({tag, ".err"}, 32'(err), e);
    check({tag, ".code"}, 32'(err_code), c);
    check({tag, ".good"}, 32'(good_cnt), g);
  endtask

  task automatic do_clr(input logic f);
    clr = 1'b1;
    cyc(f, led);
    clr = 1'b0;
  endtask

  initial begin
    #23;
    status("reset", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    status("idle", 0, 0, 0, 0);
    // ideal stream: prime, then two good periods lock
    pulse(1'b1); status("p1", 0, 0, 0, 0); idle(6);
    pulse(1'b1); status("p2", 0, 0, 0, 1); idle(6);
    pulse(1'b1); status("p3", 1, 0, 0, 2); idle(6);
    pulse(1'b1); status("p4", 1, 0, 0, 3);
    // early pulse at gap 5
    idle(4);
    cyc(1'b1, led);
    status("early", 0, 1, 1, 3);
    idle(10);
    status("early_hold", 0, 1, 1, 3);
    // clr wins over an early flg in FAULT
    do_clr(1'b1);
    status("clr_flg", 0, 0, 0, 0);
    idle(2);
    pulse(1'b1); idle(6);
    pulse(1'b1); idle(6);
    pulse(1'b1); status("relock", 1, 0, 0, 2); idle(6);
    // missing pulse: gap reaches 7 with flg low
    cyc(1'b0, led);
    status("missing", 0, 1, 2, 2);
    idle(3);
    do_clr(1'b0);
    status("clr2", 0, 0, 0, 0);
    // led held across a correctly timed pulse
    pulse(1'b1); idle(6);
    pulse(1'b1); status("nt_p2", 0, 0, 0, 1); idle(6);
    pulse(1'b0); status("no_toggle", 0, 1, 3, 1);
    idle(3);
    status("no_toggle_hold", 0, 1, 3, 1);
    do_clr(1'b0);
    // consecutive flg at a non-toggled sample point: early wins
    pulse(1'b1); idle(6);
    pulse(1'b1); idle(6);
    cyc(1'b1, led);
    cyc(1'b1, led);
    status("early_vs_led", 0, 1, 1, 1);
    do_clr(1'b0);
    // long ideal stream: 2-bit counter saturates
    repeat (6) begin
      pulse(1'b1);
      idle(6);
    end
    check("sat.good", 32'(s_cnt), 3);
    check("wide.good", 32'(good_cnt), 5);
    check("sat.locked", 32'(s_locked), 1);
    // asynchronous reset mid-gap
    idle(2);
    #2;
    rst = 1'b1;
    #1;
    status("async_rst", 0, 0, 0, 0);
    check("async_rst.sat", 32'(s_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    status("post_rst", 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
